// File: rtl/peak_pkg.sv
// Shared types and defaults for the peak tracker: FSM state encoding and
// default window geometry.
package peak_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_COUNT_N = 16;

  typedef enum logic {
    ACCUM,
    HOLD
  } peak_state_t;

endpackage

// File: rtl/peak_tracker_if.sv
// Sample-in / summary-out handshake bundle for the peak tracker.
interface peak_tracker_if import peak_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned IDX_W = $clog2(DEF_COUNT_N)
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [WIDTH-1:0] out_min;
  logic [IDX_W-1:0] out_max_idx;
  logic [IDX_W-1:0] out_min_idx;
  logic [WIDTH-1:0] out_range;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_max_idx, out_min_idx, out_range
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_min, out_max_idx, out_min_idx, out_range
  );

endinterface

// File: rtl/mag_compare.sv
// Unsigned magnitude comparator: equality and strict a-greater-than-b.
module mag_compare import peak_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt
);

  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/peak_tracker.sv
// Windowed max/min tracker: accumulates COUNT_N samples, then holds the
// summary (extremes, first-occurrence indices, range) until it is consumed.
module peak_tracker import peak_pkg::*; #(
  parameter  int unsigned WIDTH   = DEF_WIDTH,
  parameter  int unsigned COUNT_N = DEF_COUNT_N,
  localparam int unsigned IDX_W   = $clog2(COUNT_N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  peak_tracker_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT_N - 1);

  peak_state_t      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;
  logic [WIDTH-1:0] range_q, range_d;

  logic max_eq, max_gt, min_eq, min_gt;
  logic accept;

  mag_compare #(.WIDTH(WIDTH)) u_cmp_max (
    .a (bus.in_data),
    .b (max_q),
    .eq(max_eq),
    .gt(max_gt)
  );

  mag_compare #(.WIDTH(WIDTH)) u_cmp_min (
    .a (bus.in_data),
    .b (min_q),
    .eq(min_eq),
    .gt(min_gt)
  );

  assign bus.in_ready    = (state_q == ACCUM) && !rst;
  assign bus.out_valid   = (state_q == HOLD);
  assign bus.out_max     = max_q;
  assign bus.out_min     = min_q;
  assign bus.out_max_idx = max_idx_q;
  assign bus.out_min_idx = min_idx_q;
  assign bus.out_range   = range_q;

  assign accept = bus.in_valid && bus.in_ready;

  // Next-state: clear overrides both handshakes; ties never move an index.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    range_d   = range_q;

    if (clear) begin
      state_d = ACCUM;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            if (cnt_q == '0) begin
              max_d     = bus.in_data;
              min_d     = bus.in_data;
              max_idx_d = '0;
              min_idx_d = '0;
            end else begin
              if (max_gt && !max_eq) begin
                max_d     = bus.in_data;
                max_idx_d = cnt_q;
              end
              if (!min_gt && !min_eq) begin
                min_d     = bus.in_data;
                min_idx_d = cnt_q;
              end
            end
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == LAST_IDX) begin
              state_d = HOLD;
              cnt_d   = '0;
              range_d = max_d - min_d;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      range_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      range_q   <= range_d;
    end
  end

endmodule

// File: tb/tb_peak_tracker.sv
// Self-checking bench for peak_tracker: directed plan items plus a random
// phase, all checked against a queue-based window model.
module tb_peak_tracker;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned COUNT_N = 4;
  localparam int unsigned IDX_W   = $clog2(COUNT_N);

  logic clk = 1'b0;
  logic rst;
  logic clear;

  peak_tracker_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  peak_tracker #(.WIDTH(WIDTH), .COUNT_N(COUNT_N)) dut (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: samples of the open window plus the values the
  // summary registers are expected to show.
  bit          m_hold;
  int unsigned win[$];
  int unsigned m_max, m_min, m_max_idx, m_min_idx, m_range;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Extremes of the samples seen so far; the earliest occurrence wins ties.
  function automatic void summarize();
    m_max = win[0]; m_max_idx = 0;
    m_min = win[0]; m_min_idx = 0;
    for (int i = 1; i < win.size(); i++) begin
      if (win[i] > m_max) begin m_max = win[i]; m_max_idx = i; end
      if (win[i] < m_min) begin m_min = win[i]; m_min_idx = i; end
    end
  endfunction

  function automatic void model_edge(input bit r, input bit clr, input bit v,
                                     input logic [7:0] d, input bit ordy);
    if (r) begin
      m_hold = 0; win.delete();
      m_max = 0; m_min = 0; m_max_idx = 0; m_min_idx = 0; m_range = 0;
    end else if (clr) begin
      m_hold = 0; win.delete();
    end else if (!m_hold) begin
      if (v) begin
        win.push_back(int'(d));
        summarize();
        if (win.size() == COUNT_N) begin
          m_range = m_max - m_min;
          m_hold  = 1;
          win.delete();
        end
      end
    end else if (ordy) begin
      m_hold = 0;
    end
  endfunction

  // One clock: drive inputs, check in_ready before the edge, then the
  // registered outputs just after it.
  task automatic cycle(input bit r, input bit clr, input bit v,
                       input logic [7:0] d, input bit ordy);
    rst = r; clear = clr;
    bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(!r && !m_hold));
    @(posedge clk);
    model_edge(r, clr, v, d, ordy);
    #1;
    check("out_valid",   32'(bus.out_valid),   32'(m_hold));
    check("out_max",     32'(bus.out_max),     m_max);
    check("out_min",     32'(bus.out_min),     m_min);
    check("out_max_idx", 32'(bus.out_max_idx), m_max_idx);
    check("out_min_idx", 32'(bus.out_min_idx), m_min_idx);
    check("out_range",   32'(bus.out_range),   m_range);
  endtask

  task automatic feed(input logic [7:0] d);
    cycle(0, 0, 1, d, 0);
  endtask

  logic [7:0] stream[$];
  logic [6:0] vpat;

  initial begin
    m_hold = 0;
    m_max = 0; m_min = 0; m_max_idx = 0; m_min_idx = 0; m_range = 0;

    // 1: reset for two cycles, then an idle cycle
    cycle(1, 0, 1, 8'hAA, 1);
    cycle(1, 0, 1, 8'hAA, 1);
    cycle(0, 0, 0, 8'h00, 0);

    // 2: mixed window
    stream = '{8'h10, 8'h80, 8'h03, 8'h7F};
    foreach (stream[i]) feed(stream[i]);
    check("t2_valid",   32'(bus.out_valid),   32'd1);
    check("t2_max",     32'(bus.out_max),     32'h80);
    check("t2_max_idx", 32'(bus.out_max_idx), 32'd1);
    check("t2_min",     32'(bus.out_min),     32'h03);
    check("t2_min_idx", 32'(bus.out_min_idx), 32'd2);
    check("t2_range",   32'(bus.out_range),   32'h7D);
    cycle(0, 0, 0, 8'h00, 1);

    // 3: all-equal window, then alternating extremes
    repeat (4) feed(8'h55);
    check("t3_range", 32'(bus.out_range), 32'd0);
    cycle(0, 0, 0, 8'h00, 1);
    stream = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    foreach (stream[i]) feed(stream[i]);
    check("t3_max_idx", 32'(bus.out_max_idx), 32'd1);
    check("t3_min_idx", 32'(bus.out_min_idx), 32'd0);

    // 4: stall in HOLD with in_valid asserted
    repeat (5) cycle(0, 0, 1, 8'hEE, 0);
    cycle(0, 0, 1, 8'hEE, 1);
    stream = '{8'h09, 8'h08, 8'h0A, 8'h07};
    foreach (stream[i]) feed(stream[i]);
    check("t4_min_idx", 32'(bus.out_min_idx), 32'd3);
    cycle(0, 0, 0, 8'h00, 1);

    // 5: clear mid-window with a concurrent valid sample
    feed(8'hC0); feed(8'h02);
    cycle(0, 1, 1, 8'hF0, 0);
    stream = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (stream[i]) feed(stream[i]);
    check("t5_max_idx", 32'(bus.out_max_idx), 32'd3);
    check("t5_max",     32'(bus.out_max),     32'h04);
    cycle(0, 0, 0, 8'h00, 1);

    // 6: gaps in in_valid
    stream = '{8'h20, 8'h40, 8'h10, 8'h30};
    vpat = 7'b1011001;
    for (int i = 0, k = 0; i < 7; i++) begin
      if (vpat[6-i]) begin cycle(0, 0, 1, stream[k], 0); k++; end
      else cycle(0, 0, 0, 8'hFF, 0);
    end
    check("t6_max", 32'(bus.out_max), 32'h40);
    check("t6_min_idx", 32'(bus.out_min_idx), 32'd2);
    cycle(0, 0, 0, 8'h00, 1);

    // Random phase: occasional reset/clear, narrow data to force ties
    for (int n = 0; n < 1500; n++) begin
      automatic bit r    = ($urandom_range(0, 199) == 0);
      automatic bit clr  = ($urandom_range(0, 49) == 0);
      automatic bit v    = ($urandom_range(0, 3) != 0);
      automatic bit ordy = ($urandom_range(0, 1) == 1);
      automatic logic [7:0] d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7))
                                                            : 8'($urandom);
      cycle(r, clr, v, d, ordy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
